// File: rtl/cw_sidetone_ctrl.sv
// CW sidetone sequencer: synchronises the key, shapes each element with a linear
// profile envelope, freezes tone/volume per element and locks out a stuck key.
module cw_sidetone_ctrl #(
  parameter logic [12:0] RAMP_DIV      = 13'd4800,
  parameter logic [6:0]  PMAX          = 7'h4D,
  parameter logic [19:0] TIMEOUT_TICKS = 20'd160000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cw_keydown,
  input  logic        cw_enable,
  input  logic [11:0] tonefreq_in,
  input  logic [7:0]  volume_in,
  output logic        tone_enb,
  output logic [6:0]  profile,
  output logic [11:0] tonefreq,
  output logic [7:0]  audiovolume,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } state_t;

  state_t      state_q;
  logic        key_meta_q;
  logic        key_s_q;
  logic [12:0] div_q;
  logic [19:0] tmo_cnt_q;
  logic [6:0]  profile_q;
  logic        tone_enb_q;
  logic [11:0] tonefreq_q;
  logic [7:0]  audiovolume_q;
  logic        busy_q;
  logic        timeout_q;

  logic        tick;
  logic        key_ok;
  logic        start_ok;
  logic [11:0] tonefreq_d;
  logic [7:0]  audiovolume_d;

  assign tick     = (div_q == RAMP_DIV - 13'd1);
  assign key_ok   = key_s_q & cw_enable;
  assign start_ok = key_ok & ~timeout_q;

  always_comb begin
    tonefreq_d = tonefreq_in;
    if (tonefreq_in < 12'd200) begin
      tonefreq_d = 12'd200;
    end else if (tonefreq_in > 12'd2250) begin
      tonefreq_d = 12'd2250;
    end
    audiovolume_d = volume_in[7] ? 8'd127 : volume_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      key_meta_q    <= 1'b0;
      key_s_q       <= 1'b0;
      div_q         <= '0;
      tmo_cnt_q     <= '0;
      profile_q     <= '0;
      tone_enb_q    <= 1'b0;
      tonefreq_q    <= '0;
      audiovolume_q <= '0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      key_meta_q <= cw_keydown;
      key_s_q    <= key_meta_q;
      div_q      <= tick ? 13'd0 : div_q + 13'd1;
      tmo_cnt_q  <= '0;
      // Lockout persists only while the key stays down.
      if (!key_s_q) begin
        timeout_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          profile_q     <= '0;
          tone_enb_q    <= 1'b0;
          busy_q        <= 1'b0;
          tonefreq_q    <= tonefreq_d;
          audiovolume_q <= audiovolume_d;
          if (start_ok) begin
            state_q    <= RISE;
            tone_enb_q <= 1'b1;
            busy_q     <= 1'b1;
            div_q      <= '0;
          end
        end

        RISE: begin
          // A key change in the tick cycle wins; that step is dropped.
          if (!key_ok) begin
            state_q <= FALL;
          end else if (tick) begin
            if (profile_q >= PMAX - 7'd1) begin
              profile_q <= PMAX;
              state_q   <= ON;
            end else begin
              profile_q <= profile_q + 7'd1;
            end
          end
        end

        ON: begin
          profile_q <= PMAX;
          if (!key_ok) begin
            state_q <= FALL;
          end else if (tick) begin
            if (tmo_cnt_q == TIMEOUT_TICKS - 20'd1) begin
              timeout_q <= 1'b1;
              state_q   <= FALL;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + 20'd1;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q;
          end
        end

        FALL: begin
          // Re-press resumes from the current level without resetting the divider.
          if (start_ok) begin
            state_q <= RISE;
          end else if (tick) begin
            if (profile_q <= 7'd1) begin
              profile_q  <= '0;
              state_q    <= IDLE;
              tone_enb_q <= 1'b0;
              busy_q     <= 1'b0;
            end else begin
              profile_q <= profile_q - 7'd1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tone_enb    = tone_enb_q;
  assign profile     = profile_q;
  assign tonefreq    = tonefreq_q;
  assign audiovolume = audiovolume_q;
  assign busy        = busy_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_cw_sidetone_ctrl.sv
// Scoreboard bench for cw_sidetone_ctrl: an envelope model predicts every cycle's
// outputs into a queue, and a negedge monitor compares them against the DUT.
module tb_cw_sidetone_ctrl;

  localparam int R = 4;
  localparam int P = 8;
  localparam int T = 5;

  logic        clk;
  logic        rst;
  logic        cw_keydown;
  logic        cw_enable;
  logic [11:0] tonefreq_in;
  logic [7:0]  volume_in;
  logic        tone_enb;
  logic [6:0]  profile;
  logic [11:0] tonefreq;
  logic [7:0]  audiovolume;
  logic        busy;
  logic        timeout;

  cw_sidetone_ctrl #(
    .RAMP_DIV(13'd4),
    .PMAX(7'd8),
    .TIMEOUT_TICKS(20'd5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cw_keydown(cw_keydown),
    .cw_enable(cw_enable),
    .tonefreq_in(tonefreq_in),
    .volume_in(volume_in),
    .tone_enb(tone_enb),
    .profile(profile),
    .tonefreq(tonefreq),
    .audiovolume(audiovolume),
    .busy(busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        enb;
    logic [6:0]  prof;
    logic [11:0] freq;
    logic [7:0]  vol;
    logic        bsy;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_fail;
  int   budget_err;
  bit   done;

  // Envelope model: active flag, direction (+1 up, 0 hold, -1 down), level,
  // position within the current step period, hold-ticks and lockout.
  bit          m_active;
  int          m_dir;
  int          m_level;
  int          m_phase;
  int          m_on;
  bit          m_lock;
  logic [11:0] m_f;
  logic [7:0]  m_v;
  bit          h0;
  bit          h1;

  function automatic logic [11:0] clamp_f(input logic [11:0] f);
    if (f < 12'd200) return 12'd200;
    if (f > 12'd2250) return 12'd2250;
    return f;
  endfunction

  task automatic step(input bit r, input bit k, input bit e,
                      input logic [11:0] f, input logic [7:0] v);
    int n_level, n_phase, n_on, n_dir;
    bit n_active, n_lock, key_s, ok, tick;
    exp_t x;
    rst = r;
    cw_keydown = k;
    cw_enable = e;
    tonefreq_in = f;
    volume_in = v;
    if (r) begin
      m_active = 0; m_dir = 0; m_level = 0; m_phase = 0; m_on = 0; m_lock = 0;
      m_f = '0; m_v = '0; h0 = 0; h1 = 0;
    end else begin
      key_s = h1;
      ok = key_s && e;
      tick = (m_phase == R - 1);
      n_phase = tick ? 0 : m_phase + 1;
      n_active = m_active;
      n_dir = m_dir;
      n_level = m_level;
      n_lock = key_s ? m_lock : 1'b0;
      n_on = (m_active && m_dir == 0) ? m_on : 0;
      if (!m_active) begin
        n_level = 0;
        m_f = clamp_f(f);
        m_v = v[7] ? 8'd127 : v;
        if (ok && !m_lock) begin
          n_active = 1; n_dir = 1; n_phase = 0;
        end
      end else if (m_dir == 1) begin
        if (!ok) n_dir = -1;
        else if (tick) begin
          n_level = m_level + 1;
          if (n_level >= P) begin n_level = P; n_dir = 0; end
        end
      end else if (m_dir == 0) begin
        if (!ok) n_dir = -1;
        else if (tick) begin
          n_on = m_on + 1;
          if (n_on == T) begin n_lock = 1; n_dir = -1; end
        end
      end else begin
        if (ok && !m_lock) n_dir = 1;
        else if (tick) begin
          n_level = (m_level > 0) ? m_level - 1 : 0;
          if (n_level == 0) n_active = 0;
        end
      end
      h1 = h0;
      h0 = k;
      m_active = n_active; m_dir = n_dir; m_level = n_level;
      m_phase = n_phase; m_on = n_on; m_lock = n_lock;
    end
    x.enb = m_active;
    x.prof = 7'(m_level);
    x.freq = m_f;
    x.vol = m_v;
    x.bsy = m_active;
    x.tmo = m_lock;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int cyc, input logic [31:0] act,
                     input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, expv);
    end
  endtask

  int mon_cyc;
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("tone_enb", mon_cyc, 32'(tone_enb), 32'(e.enb));
      chk("profile", mon_cyc, 32'(profile), 32'(e.prof));
      chk("tonefreq", mon_cyc, 32'(tonefreq), 32'(e.freq));
      chk("audiovolume", mon_cyc, 32'(audiovolume), 32'(e.vol));
      chk("busy", mon_cyc, 32'(busy), 32'(e.bsy));
      chk("timeout", mon_cyc, 32'(timeout), 32'(e.tmo));
      mon_cyc++;
    end else if (done) begin
      chk("stim_budget", mon_cyc, 32'(budget_err), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit k, e;
    logic [11:0] f;
    logic [7:0] v;
    int run, g;
    n_cmp = 0; n_fail = 0; budget_err = 0; done = 0; mon_cyc = 0;

    // Reset held with key down, then a keyed element and release.
    for (int i = 0; i < 5; i++) step(1, 1, 1, 12'd600, 8'd100);
    for (int i = 0; i < 100; i++) step(0, 1, 1, 12'd600, 8'd100);
    for (int i = 0; i < 60; i++) step(0, 0, 1, 12'd600, 8'd100);
    $display("phase reset/first element done");

    // Single element with tonefreq_in changing mid-element.
    for (int i = 0; i < 100; i++) step(0, 1, 1, (i < 50) ? 12'd600 : 12'd1500, 8'd100);
    for (int i = 0; i < 60; i++) step(0, 0, 1, 12'd1500, 8'd100);
    $display("phase single element done");

    // Early release at level 3, re-press at level 2 while falling.
    g = 0;
    while (!(m_active && m_dir == 1 && m_level == 3 && m_phase == 0) && g < 200) begin
      step(0, 1, 1, 12'd700, 8'd60); g++;
    end
    if (g >= 200) budget_err++;
    g = 0;
    while (!(m_active && m_dir == -1 && m_level == 2 && m_phase == 0) && g < 200) begin
      step(0, 0, 1, 12'd700, 8'd60); g++;
    end
    if (g >= 200) budget_err++;
    for (int i = 0; i < 60; i++) step(0, 1, 1, 12'd700, 8'd60);
    for (int i = 0; i < 60; i++) step(0, 0, 1, 12'd700, 8'd60);
    $display("phase early release done");

    // Stuck key: timeout, no restart while held, then release and re-press.
    for (int i = 0; i < 150; i++) step(0, 1, 1, 12'd800, 8'd90);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 12'd800, 8'd90);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 12'd800, 8'd90);
    for (int i = 0; i < 60; i++) step(0, 0, 1, 12'd800, 8'd90);
    $display("phase timeout done");

    // Clamp boundaries on the idle config load, then an element at the top clamp.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 12'd50, 8'd200);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 12'd199, 8'd127);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 12'd2251, 8'd128);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 12'd200, 8'd0);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 12'd4000, 8'd200);
    for (int i = 0; i < 60; i++) step(0, 0, 1, 12'd4000, 8'd200);
    $display("phase clamps done");

    // Enable dropped in ON with key held; no restart until enable returns.
    g = 0;
    while (!(m_active && m_dir == 0) && g < 200) begin
      step(0, 1, 1, 12'd900, 8'd40); g++;
    end
    if (g >= 200) budget_err++;
    for (int i = 0; i < 80; i++) step(0, 1, 0, 12'd900, 8'd40);
    for (int i = 0; i < 40; i++) step(0, 1, 1, 12'd900, 8'd40);
    for (int i = 0; i < 60; i++) step(0, 0, 1, 12'd900, 8'd40);
    $display("phase enable drop done");

    // Reset mid-element with the key held.
    for (int i = 0; i < 20; i++) step(0, 1, 1, 12'd1000, 8'd30);
    for (int i = 0; i < 2; i++) step(1, 1, 1, 12'd1000, 8'd30);
    for (int i = 0; i < 30; i++) step(0, 1, 1, 12'd1000, 8'd30);
    for (int i = 0; i < 60; i++) step(0, 0, 1, 12'd1000, 8'd30);
    $display("phase mid-element reset done");

    // Random keying, enable toggles, config changes and rare resets.
    k = 0; e = 1; f = 12'd600; v = 8'd50; run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        k = ~k;
        run = $urandom_range(1, 70);
      end
      run--;
      if ($urandom_range(0, 99) == 0) e = ~e;
      if ($urandom_range(0, 19) == 0) f = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 19) == 0) v = 8'($urandom_range(0, 255));
      step($urandom_range(0, 599) == 0, k, e, f, v);
    end
    $display("phase random done");

    done = 1;
  end

endmodule

// File: doc/cw_sidetone_ctrl.md
# cw_sidetone_ctrl

Sequencer that drives the CW sidetone generator's control inputs (`tone_enb`, `profile`, `tonefreq`, `audiovolume`) from the keyer's key-down signal. It shapes each keyed element with a linear rise/fall envelope on `profile` to suppress clicks. It freezes tone and volume settings for the duration of an element and enforces a stuck-key timeout. It sits between the CW keyer/host-register block and the sidetone generator in the 76.8 MHz local-audio domain.

## Interface
Parameters:
- `RAMP_DIV`, 13'd4800: clk cycles per envelope step (62.5 µs at 76.8 MHz).
- `PMAX`, 7'h4D: full-scale profile value.
- `TIMEOUT_TICKS`, 20'd160000: ramp ticks in ON before forced release (10 s).

Ports (one clock, `clk`; reset `rst` is synchronous and active-high):
- `clk` in 1: 76.8 MHz system clock.
- `rst` in 1: synchronous, active-high reset.
- `cw_keydown` in 1: key state, asynchronous to clk.
- `cw_enable` in 1: sidetone permitted.
- `tonefreq_in` in 12: requested tone in Hz.
- `volume_in` in 8: requested volume.
- `tone_enb` out 1: generator enable. Low resets the generator phase.
- `profile` out 7: envelope amplitude, 0..PMAX.
- `tonefreq` out 12: frozen tone frequency, 200..2250.
- `audiovolume` out 8: frozen volume, 0..127.
- `busy` out 1: state != IDLE.
- `timeout` out 1: stuck-key lockout active.

## Operation
- **Key synchronizer:** `cw_keydown` passes through 2 flops to produce `key_s`. Only `key_s` is used internally.
- **Divider:** counts 0..RAMP_DIV-1 and emits `tick` on the count RAMP_DIV-1.
  - Cleared to 0 on the IDLE->RISE transition.
  - Free-runs in all other states.
- **Config latch:**
  - Loads every cycle while in IDLE, or while taking the IDLE->RISE transition. Held constant in all other states.
  - `tonefreq` is the clamp of `tonefreq_in`: values below 200 load 200, values above 2250 load 2250.
  - `audiovolume`: if `volume_in[7]`=1 it loads 8'd127, otherwise `volume_in`.
- **State machine:** states IDLE, RISE, ON, FALL.
  - IDLE: `profile`=0, `tone_enb`=0. If `key_s` & `cw_enable` & !`timeout`, go to RISE and set `tone_enb`=1.
  - RISE: on `tick`, `profile` increments by 1.
    - On the tick where `profile` becomes PMAX, go to ON.
    - If `!key_s | !cw_enable`, go to FALL on the next cycle, keeping the current `profile`. This has priority over tick.
  - ON: `profile`=PMAX. The timeout counter increments on each `tick`.
    - If `!key_s | !cw_enable`, go to FALL.
    - If the counter reaches TIMEOUT_TICKS, set `timeout`=1 and go to FALL.
  - FALL: on `tick`, `profile` decrements by 1.
    - On the tick where `profile` becomes 0, go to IDLE and drop `tone_enb` in the same edge.
    - If `key_s` & `cw_enable` & !`timeout`, return to RISE from the current `profile`. This has priority over tick, and the divider is not cleared.
- **Timeout counter:** cleared whenever the state is not ON.
- **`timeout` flag:** cleared when `key_s`=0, in any state.
- **`profile` saturation:** never exceeds PMAX and never goes below 0.

## Timing
- Reset values: state IDLE, `profile`=0, `tone_enb`=0, `tonefreq`=0, `audiovolume`=0, `busy`=0, `timeout`=0. Divider, timeout counter and sync flops are all 0.
  - Config outputs take valid values one cycle after `rst` releases, through the IDLE load.
- Key-to-`tone_enb` latency: 3 clk cycles (2 sync flops plus the state register).
- First `profile` increment: RAMP_DIV cycles after entering RISE.
- Full rise, and full fall, takes PMAX×RAMP_DIV cycles.
- Release-to-FALL decision: 3 cycles after the `cw_keydown` edge.
- A `tick` and a key change in the same cycle: the key change wins and the tick's step is discarded.
- `rst` asserted mid-element: all outputs return to their reset values on the next edge, with no fall ramp.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- **Reset:** hold `rst` for 5 cycles while `cw_keydown`=1. Expect all outputs at their reset values. One cycle after release, expect `tonefreq`=`tonefreq_in` (within range) and `busy` to go to 1 three cycles later.
- **Single element** (RAMP_DIV=4, PMAX=8): key 100 cycles with `tonefreq_in`=600 and `volume_in`=100.
  - `profile` steps 0..8 every 4 cycles and holds at 8.
  - After release, it steps down to 0.
  - `tone_enb` falls on the edge where `profile` becomes 0.
  - `tonefreq` stays 600 even if `tonefreq_in` changes mid-element.
- **Early release** (RAMP_DIV=4, PMAX=8): release when `profile`=3. Expect FALL from 3 to 0 with no step above 3.
  - Re-press when `profile`=2: expect RISE resuming from 2.
  - `tone_enb` stays 1 throughout.
- **Timeout** (TIMEOUT_TICKS=5): hold key continuously.
  - Expect `timeout`=1 after 5 ticks in ON, then a fall to IDLE.
  - No restart while the key is held.
  - Release then re-press: `timeout` clears and a new RISE starts.
- **Clamps:** with `tonefreq_in`=50 expect 200; with 4000 expect 2250; with `volume_in`=200 expect 127.
- **Enable drop:** deassert `cw_enable` in ON. Expect FALL to 0 and IDLE. No RISE while `cw_enable`=0, even with the key held.
